// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: a small circular FIFO drained by a baud-rate FSM onto txd.
// Optional `UART_TX_CRLF_EN: a CR frame is sent ahead of every LF taken from the FIFO.
module uart_tx_buffer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rstd,
    input  logic [7:0]               uart,
    input  logic                     uart_we,
    output logic                     txd,
    output logic                     busy,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q;

    state_e        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          txd_q;

    logic          push;
    logic          pop;
    logic          load;
    logic          bit_end;
    logic [7:0]    load_byte;

    assign full    = (level_q == LEVEL_FULL);
    assign push    = uart_we && !full;
    assign bit_end = (baud_q == BAUD_LAST);
    // A new frame is loaded from IDLE or straight out of the last STOP cycle, so frames abut.
    assign load    = (level_q != '0) && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

`ifdef UART_TX_CRLF_EN
    logic cr_pend_q;
    logic insert_cr;

    assign insert_cr = (mem_q[rd_ptr_q] == 8'h0A) && !cr_pend_q;
    assign pop       = load && !insert_cr;
    assign load_byte = insert_cr ? 8'h0D : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            cr_pend_q <= 1'b0;
        end else if (load) begin
            cr_pend_q <= insert_cr;
        end
    end
`else
    assign pop       = load;
    assign load_byte = mem_q[rd_ptr_q];
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: storage carries no reset; validity is tracked by the pointers and level alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= uart;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_q | (uart_we && full);
        end
    end

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (load) begin
                        shift_q   <= load_byte;
                        bit_idx_q <= '0;
                        txd_q     <= 1'b0;
                        state_q   <= START;
                    end else begin
                        txd_q <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            txd_q     <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (load) begin
                            shift_q   <= load_byte;
                            bit_idx_q <= '0;
                            txd_q     <= 1'b0;
                            state_q   <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign txd      = txd_q;
    assign busy     = (state_q != IDLE) || (level_q != '0);
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer with CLKS_PER_BIT=4, DEPTH=4.
// Honors `UART_TX_CRLF_EN to choose the expected LF handling.
module tb_uart_tx_buffer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rstd;
    logic [7:0] uart;
    logic       uart_we;
    logic       txd;
    logic       busy;
    logic       full;
    logic       overflow;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    uart_tx_buffer #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstd     (rstd),
        .uart     (uart),
        .uart_we  (uart_we),
        .txd      (txd),
        .busy     (busy),
        .full     (full),
        .overflow (overflow),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level in cycle k of a frame carrying byte b (start, 8 data LSB first, stop).
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        int slot;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    // Called just after the edge that starts a frame; returns just after the edge that ends it.
    task automatic check_frame(input logic [7:0] b);
        for (int k = 0; k < 10 * CPB; k++) begin
            check($sformatf("txd frame %02h cyc %0d", b, k), {31'd0, txd}, {31'd0, exp_bit(b, k)});
            if (k == 0) check("busy in frame", {31'd0, busy}, 32'd1);
            tick();
        end
    endtask

    initial begin
        int lvl_max;
        logic [7:0] burst [6];

        rstd    = 1'b1;
        uart    = 8'h00;
        uart_we = 1'b0;
        tick();
        tick();
        check("reset txd", {31'd0, txd}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset full", {31'd0, full}, 32'd0);
        check("reset overflow", {31'd0, overflow}, 32'd0);
        check("reset level", {29'd0, level}, 32'd0);
        rstd = 1'b0;

        // Idle after reset
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle txd", {31'd0, txd}, 32'd1);
            check("idle busy", {31'd0, busy}, 32'd0);
            check("idle level", {29'd0, level}, 32'd0);
        end

        // Single byte 0xA5
        uart    = 8'hA5;
        uart_we = 1'b1;
        tick();
        uart_we = 1'b0;
        check("a5 level after push", {29'd0, level}, 32'd1);
        check("a5 busy after push", {31'd0, busy}, 32'd1);
        check("a5 txd before pop", {31'd0, txd}, 32'd1);
        tick();
        check("a5 level after pop", {29'd0, level}, 32'd0);
        check_frame(8'hA5);
        check("a5 busy after frame", {31'd0, busy}, 32'd0);
        check("a5 txd after frame", {31'd0, txd}, 32'd1);
        for (int i = 0; i < 5; i++) tick();

        // Three consecutive pushes, back-to-back frames
        burst[0] = 8'h41; burst[1] = 8'h42; burst[2] = 8'h43;
        lvl_max = 0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    uart    = burst[i];
                    uart_we = 1'b1;
                    tick();
                    if (int'(level) > lvl_max) lvl_max = int'(level);
                end
                uart_we = 1'b0;
            end
            begin
                tick();
                tick();
                for (int f = 0; f < 3; f++) check_frame(burst[f]);
            end
        join
        check("abc level peak", lvl_max, 32'd2);
        check("abc busy after", {31'd0, busy}, 32'd0);
        check("abc overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 5; i++) tick();

        // Six consecutive pushes: one popped, four buffered, sixth dropped
        for (int i = 0; i < 6; i++) burst[i] = 8'h10 + 8'(i * 17);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    uart    = burst[i];
                    uart_we = 1'b1;
                    tick();
                    if (i == 3) check("burst not yet full", {31'd0, full}, 32'd0);
                    if (i == 4) begin
                        check("burst full", {31'd0, full}, 32'd1);
                        check("burst level 4", {29'd0, level}, 32'd4);
                        check("burst overflow before drop", {31'd0, overflow}, 32'd0);
                    end
                    if (i == 5) begin
                        check("burst overflow after drop", {31'd0, overflow}, 32'd1);
                        check("burst level after drop", {29'd0, level}, 32'd4);
                    end
                end
                uart_we = 1'b0;
            end
            begin
                tick();
                tick();
                for (int f = 0; f < 5; f++) check_frame(burst[f]);
            end
        join
        check("burst busy after", {31'd0, busy}, 32'd0);
        check("burst level after", {29'd0, level}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            check("burst no sixth frame", {31'd0, txd}, 32'd1);
            tick();
        end
        check("burst overflow sticky", {31'd0, overflow}, 32'd1);

        // Reset during DATA of the first frame with two bytes queued
        burst[0] = 8'h00; burst[1] = 8'h33; burst[2] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            uart    = burst[i];
            uart_we = 1'b1;
            tick();
        end
        uart_we = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("midreset txd low in data", {31'd0, txd}, 32'd0);
        check("midreset level queued", {29'd0, level}, 32'd2);
        #3 rstd = 1'b1;
        #1;
        check("midreset txd immediate", {31'd0, txd}, 32'd1);
        check("midreset level cleared", {29'd0, level}, 32'd0);
        check("midreset busy cleared", {31'd0, busy}, 32'd0);
        check("midreset overflow cleared", {31'd0, overflow}, 32'd0);
        rstd = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            check("post reset txd idle", {31'd0, txd}, 32'd1);
            check("post reset busy", {31'd0, busy}, 32'd0);
        end

        // Line feed handling
        uart    = 8'h0A;
        uart_we = 1'b1;
        tick();
        uart_we = 1'b0;
        check("lf level after push", {29'd0, level}, 32'd1);
        tick();
`ifdef UART_TX_CRLF_EN
        check("lf level during cr", {29'd0, level}, 32'd1);
        check_frame(8'h0D);
        check("lf level after cr", {29'd0, level}, 32'd0);
        check_frame(8'h0A);
`else
        check("lf level after pop", {29'd0, level}, 32'd0);
        check_frame(8'h0A);
`endif
        check("lf busy after", {31'd0, busy}, 32'd0);
        check("lf txd after", {31'd0, txd}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
